flag_branch_ctrl: RTL and testbench

FLAG_BRANCH_CTRL -- requirements
Module: flag_branch_ctrl

---
 rtl/flag_branch_ctrl.sv | 147 ++++++++++++++
 tb/tb_flag_branch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_ctrl
// Description : Condition-flag register and ID-stage branch resolution.
//               Holds the architectural {N,Z,C,V} flags, resolves B, CBZ
//               and B.cond with same-cycle flag forwarding from EX, squashes
//               the wrong-path slot after a taken branch, and keeps a
//               saturating count of taken branches.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_setflags,
  input  logic [3:0]  ex_flags,
  input  logic        id_valid,
  input  logic [1:0]  id_br_type,
  input  logic [3:0]  id_cond,
  input  logic        id_reg_zero,
  output logic        br_taken,
  output logic        flush_id,
  output logic [3:0]  flags_q,
  output logic [15:0] taken_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [1:0]  C_BR_NONE = 2'b00;
  localparam logic [1:0]  C_BR_B    = 2'b01;
  localparam logic [1:0]  C_BR_CBZ  = 2'b10;
  localparam logic [1:0]  C_BR_COND = 2'b11;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_flags;
  logic [15:0] r_taken_cnt;
  logic [3:0]  w_eff_flags;
  logic        w_n, w_z, w_c, w_v;
  logic        w_cond_true;
  logic        w_take;
  logic        w_br_taken;
  logic        w_flush_id;

  // Flags written by EX this cycle win over the register so a B.cond right
  // behind a flag-setting instruction sees the new values.
  assign w_eff_flags = ex_setflags ? ex_flags : r_flags;
  assign w_n = w_eff_flags[3];
  assign w_z = w_eff_flags[2];
  assign w_c = w_eff_flags[1];
  assign w_v = w_eff_flags[0];

  // ARM condition-code decode against the effective flags.
  always_comb begin
    w_cond_true = 1'b0;
    case (id_cond)
      4'h0:    w_cond_true = w_z;
      4'h1:    w_cond_true = ~w_z;
      4'h2:    w_cond_true = w_c;
      4'h3:    w_cond_true = ~w_c;
      4'h4:    w_cond_true = w_n;
      4'h5:    w_cond_true = ~w_n;
      4'h6:    w_cond_true = w_v;
      4'h7:    w_cond_true = ~w_v;
      4'h8:    w_cond_true = w_c & ~w_z;
      4'h9:    w_cond_true = ~w_c | w_z;
      4'hA:    w_cond_true = (w_n == w_v);
      4'hB:    w_cond_true = (w_n != w_v);
      4'hC:    w_cond_true = ~w_z & (w_n == w_v);
      4'hD:    w_cond_true = w_z | (w_n != w_v);
      default: w_cond_true = 1'b1;
    endcase
  end

  // Per-branch-type take condition.
  always_comb begin
    w_take = 1'b0;
    case (id_br_type)
      C_BR_NONE: w_take = 1'b0;
      C_BR_B:    w_take = 1'b1;
      C_BR_CBZ:  w_take = id_reg_zero;
      C_BR_COND: w_take = w_cond_true;
      default:   w_take = 1'b0;
    endcase
  end

  // Next-state and outputs: a branch is only taken from IDLE when not
  // stalled; FLUSH ignores ID (wrong-path slot) and flush_id follows state.
  always_comb begin
    w_state_next = r_state;
    w_br_taken   = 1'b0;
    w_flush_id   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_br_taken = id_valid & ~stall & w_take & ~reset;
        if (w_br_taken) begin
          w_state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_flush_id = ~reset;
        if (!stall) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register; reset overrides stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Architectural flags: written by EX unless the pipe is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (ex_setflags && !stall) begin
      r_flags <= ex_flags;
    end
  end

  // Taken-branch counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt <= 16'h0000;
    end else if (w_br_taken && (r_taken_cnt != C_CNT_MAX)) begin
      r_taken_cnt <= r_taken_cnt + 16'h0001;
    end
  end

  assign br_taken  = w_br_taken;
  assign flush_id  = w_flush_id;
  assign flags_q   = r_flags;
  assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flag_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_ctrl
// Description : Directed, table-driven bench for flag_branch_ctrl plus
//               hand-written sequences for stall, reset and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        ex_setflags;
  logic [3:0]  ex_flags;
  logic        id_valid;
  logic [1:0]  id_br_type;
  logic [3:0]  id_cond;
  logic        id_reg_zero;
  logic        br_taken;
  logic        flush_id;
  logic [3:0]  flags_q;
  logic [15:0] taken_cnt;

  int n_vec;
  int n_bad;
  logic [15:0] exp_cnt;

  flag_branch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .ex_setflags (ex_setflags),
    .ex_flags    (ex_flags),
    .id_valid    (id_valid),
    .id_br_type  (id_br_type),
    .id_cond     (id_cond),
    .id_reg_zero (id_reg_zero),
    .br_taken    (br_taken),
    .flush_id    (flush_id),
    .flags_q     (flags_q),
    .taken_cnt   (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       set;
    logic [3:0] fl;
    logic [1:0] bt;
    logic [3:0] cond;
    logic       rz;
    logic       valid;
    logic       exp_tk;
    logic [3:0] exp_fq;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset       = 1'b0;
    stall       = 1'b0;
    ex_setflags = 1'b0;
    ex_flags    = 4'b0000;
    id_valid    = 1'b0;
    id_br_type  = 2'b00;
    id_cond     = 4'h0;
    id_reg_zero = 1'b0;
  endtask

  task automatic drive_b();
    id_valid   = 1'b1;
    id_br_type = 2'b01;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    exp_cnt = 16'h0000;

    //            set  flags    type   cond  rz    vld   tk    flags_q
    tbl[0]  = '{1'b1, 4'b0100, 2'b11, 4'h0, 1'b0, 1'b1, 1'b1, 4'b0100}; // EQ forwarded
    tbl[1]  = '{1'b0, 4'b0000, 2'b11, 4'h1, 1'b0, 1'b1, 1'b0, 4'b0100}; // NE
    tbl[2]  = '{1'b1, 4'b0010, 2'b11, 4'h2, 1'b0, 1'b1, 1'b1, 4'b0010}; // HS
    tbl[3]  = '{1'b0, 4'b0000, 2'b11, 4'h3, 1'b0, 1'b1, 1'b0, 4'b0010}; // LO
    tbl[4]  = '{1'b0, 4'b0000, 2'b11, 4'h8, 1'b0, 1'b1, 1'b1, 4'b0010}; // HI
    tbl[5]  = '{1'b1, 4'b0110, 2'b11, 4'h9, 1'b0, 1'b1, 1'b1, 4'b0110}; // LS
    tbl[6]  = '{1'b1, 4'b1000, 2'b11, 4'hB, 1'b0, 1'b1, 1'b1, 4'b1000}; // LT
    tbl[7]  = '{1'b0, 4'b0000, 2'b11, 4'hA, 1'b0, 1'b1, 1'b0, 4'b1000}; // GE
    tbl[8]  = '{1'b0, 4'b0000, 2'b11, 4'h4, 1'b0, 1'b1, 1'b1, 4'b1000}; // MI
    tbl[9]  = '{1'b0, 4'b0000, 2'b11, 4'h5, 1'b0, 1'b1, 1'b0, 4'b1000}; // PL
    tbl[10] = '{1'b1, 4'b1001, 2'b11, 4'hA, 1'b0, 1'b1, 1'b1, 4'b1001}; // GE
    tbl[11] = '{1'b0, 4'b0000, 2'b11, 4'hC, 1'b0, 1'b1, 1'b1, 4'b1001}; // GT
    tbl[12] = '{1'b0, 4'b0000, 2'b11, 4'hD, 1'b0, 1'b1, 1'b0, 4'b1001}; // LE
    tbl[13] = '{1'b0, 4'b0000, 2'b11, 4'h6, 1'b0, 1'b1, 1'b1, 4'b1001}; // VS
    tbl[14] = '{1'b0, 4'b0000, 2'b11, 4'h7, 1'b0, 1'b1, 1'b0, 4'b1001}; // VC
    tbl[15] = '{1'b0, 4'b0000, 2'b11, 4'hE, 1'b0, 1'b1, 1'b1, 4'b1001}; // AL
    tbl[16] = '{1'b0, 4'b0000, 2'b11, 4'hF, 1'b0, 1'b1, 1'b1, 4'b1001}; // NV=always
    tbl[17] = '{1'b0, 4'b0000, 2'b00, 4'hE, 1'b1, 1'b1, 1'b0, 4'b1001}; // no branch
    tbl[18] = '{1'b0, 4'b0000, 2'b01, 4'h0, 1'b0, 1'b0, 1'b0, 4'b1001}; // B, invalid
    tbl[19] = '{1'b0, 4'b0000, 2'b01, 4'h0, 1'b0, 1'b1, 1'b1, 4'b1001}; // B
    tbl[20] = '{1'b0, 4'b0000, 2'b10, 4'h0, 1'b0, 1'b1, 1'b0, 4'b1001}; // CBZ nz
    tbl[21] = '{1'b0, 4'b0000, 2'b10, 4'h0, 1'b1, 1'b1, 1'b1, 4'b1001}; // CBZ z
    tbl[22] = '{1'b1, 4'b0100, 2'b11, 4'h1, 1'b0, 1'b1, 1'b0, 4'b0100}; // NE fwd Z=1

    // ---------------- reset state ----------------
    drive_idle();
    reset = 1'b1;
    drive_b();
    step();
    #1;
    chk("rst_br_taken", {15'd0, br_taken}, 16'd0);
    chk("rst_flush", {15'd0, flush_id}, 16'd0);
    chk("rst_flags", {12'd0, flags_q}, 16'd0);
    chk("rst_cnt", taken_cnt, 16'd0);

    // ---------------- table of single branches ----------------
    for (int i = 0; i < 23; i++) begin
      drive_idle();
      ex_setflags = tbl[i].set;
      ex_flags    = tbl[i].fl;
      id_valid    = tbl[i].valid;
      id_br_type  = tbl[i].bt;
      id_cond     = tbl[i].cond;
      id_reg_zero = tbl[i].rz;
      #1;
      chk($sformatf("v%0d_br_taken", i), {15'd0, br_taken}, {15'd0, tbl[i].exp_tk});
      chk($sformatf("v%0d_flush_idle", i), {15'd0, flush_id}, 16'd0);
      step();
      chk($sformatf("v%0d_flags_q", i), {12'd0, flags_q}, {12'd0, tbl[i].exp_fq});
      if (tbl[i].exp_tk) begin
        exp_cnt++;
        // Wrong-path slot: ID still presents a takeable B, must be ignored.
        ex_setflags = 1'b0;
        drive_b();
        #1;
        chk($sformatf("v%0d_flush", i), {15'd0, flush_id}, 16'd1);
        chk($sformatf("v%0d_wrongpath", i), {15'd0, br_taken}, 16'd0);
        step();
      end
    end
    drive_idle();
    #1;
    chk("tbl_flush_cleared", {15'd0, flush_id}, 16'd0);
    chk("tbl_cnt", taken_cnt, exp_cnt);

    // ---------------- stall held in FLUSH for 3 cycles ----------------
    drive_idle();
    drive_b();
    #1;
    chk("stl_take", {15'd0, br_taken}, 16'd1);
    step();
    exp_cnt++;
    stall       = 1'b1;
    ex_setflags = 1'b1;
    ex_flags    = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stl_flush%0d", k), {15'd0, flush_id}, 16'd1);
      chk($sformatf("stl_br%0d", k), {15'd0, br_taken}, 16'd0);
      step();
      chk($sformatf("stl_cnt%0d", k), taken_cnt, exp_cnt);
      chk($sformatf("stl_flags%0d", k), {12'd0, flags_q}, 16'h0004);
    end
    stall       = 1'b0;
    ex_setflags = 1'b0;
    #1;
    chk("stl_flush_release", {15'd0, flush_id}, 16'd1);
    chk("stl_br_release", {15'd0, br_taken}, 16'd0);
    step();
    id_valid = 1'b0;
    #1;
    chk("stl_idle", {15'd0, flush_id}, 16'd0);

    // ---------------- stall in IDLE blocks a branch ----------------
    drive_idle();
    drive_b();
    stall = 1'b1;
    #1;
    chk("stl_idle_br", {15'd0, br_taken}, 16'd0);
    step();
    drive_idle();
    #1;
    chk("stl_idle_noflush", {15'd0, flush_id}, 16'd0);
    chk("stl_idle_cnt", taken_cnt, exp_cnt);

    // ---------------- reset on the cycle after a taken branch ----------------
    drive_idle();
    ex_setflags = 1'b1;
    ex_flags    = 4'b1010;
    drive_b();
    #1;
    chk("rfl_take", {15'd0, br_taken}, 16'd1);
    step();
    drive_idle();
    reset = 1'b1;
    #1;
    chk("rfl_flush_in_reset", {15'd0, flush_id}, 16'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rfl_flush", {15'd0, flush_id}, 16'd0);
    chk("rfl_flags", {12'd0, flags_q}, 16'd0);
    chk("rfl_cnt", taken_cnt, 16'd0);

    // ---------------- saturation ----------------
    drive_idle();
    force dut.r_taken_cnt = 16'hFFFE;
    #1;
    release dut.r_taken_cnt;
    #1;
    chk("sat_preload", taken_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      drive_b();
      #1;
      chk($sformatf("sat_take%0d", k), {15'd0, br_taken}, 16'd1);
      step();
      drive_idle();
      step();
      chk($sformatf("sat_cnt%0d", k), taken_cnt, 16'hFFFF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
